// File: rtl/parser_rule_cfg_master_pkg.sv
// Shared types for the rule-configuration bus master: FSM states, queued command, table selects.
package parser_rule_cfg_master_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RSP     = 2'd3
    } cfg_state_t;

    // Rule table selects carried in addr[10:8]
    localparam logic [2:0] RULE_SEL_RULE = 3'd0;
    localparam logic [2:0] TYPE_DATA     = 3'd1;
    localparam logic [2:0] TYPE_OFS      = 3'd2;
    localparam logic [2:0] KEY_OFS       = 3'd3;
    localparam logic [2:0] HEAD_SHIFT    = 3'd4;
    localparam logic [2:0] META_SHIFT    = 3'd5;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cfg_cmd_t;

    function automatic logic cfg_sel_legal(input logic [2:0] sel);
        return (sel <= META_SHIFT);
    endfunction

endpackage

// File: rtl/parser_rule_cfg_master_cmd_fifo.sv
// Purpose: synchronous FIFO of queued rule-bus commands, wrap-bit pointers for full/empty.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: caller gates push with !full (or full with a same-cycle pop); pop only when !empty.
module parser_rule_cfg_master_cmd_fifo
    import parser_rule_cfg_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_vld,
    input  cfg_cmd_t push_dat,
    input  logic     pop_rdy,
    output cfg_cmd_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    cfg_cmd_t       mem [DEPTH];
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_vld) wptr <= wptr + 1'b1;
            if (pop_rdy)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rptr[AW-1:0]];
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/parser_rule_cfg_master.sv
// Purpose: queues host commands and serialises them as single-cycle rule-bus reads/writes.
// Latency: strobe 1 cycle after a command reaches an idle FIFO head; read response 1 cycle after rdata_valid.
// Backpressure: o_cmd_ready drops when the FIFO is full; responses held until i_rsp_ready.
module parser_rule_cfg_master
    import parser_rule_cfg_master_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int RD_TIMEOUT = 64,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_wr,
    input  logic [31:0]          i_cmd_addr,
    input  logic [31:0]          i_cmd_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic                 o_rule_wren,
    output logic                 o_rule_rden,
    output logic [31:0]          o_rule_addr,
    output logic [31:0]          o_rule_wdata,
    input  logic                 i_rule_rdata_valid,
    input  logic [31:0]          i_rule_rdata,
    output logic                 o_busy,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int              TMR_W    = $clog2(RD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

    cfg_state_t       state;
    cfg_cmd_t         cmd_in;
    cfg_cmd_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             hold_wr;
    logic             hold_legal;
    logic             head_legal;
    logic [TMR_W-1:0] timer;

    assign cmd_in      = '{wr: i_cmd_wr, addr: i_cmd_addr, wdata: i_cmd_wdata};
    assign pop         = (state == IDLE) && !fifo_empty;
    // A full FIFO still accepts a push in the cycle its head is popped.
    assign o_cmd_ready = !fifo_full || pop;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign head_legal  = cfg_sel_legal(head.addr[10:8]);
    assign o_busy      = !fifo_empty || (state != IDLE);

    parser_rule_cfg_master_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push_vld (push),
        .push_dat (cmd_in),
        .pop_rdy  (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            hold_wr      <= 1'b0;
            hold_legal   <= 1'b0;
            timer        <= '0;
            o_rule_wren  <= 1'b0;
            o_rule_rden  <= 1'b0;
            o_rule_addr  <= '0;
            o_rule_wdata <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_rsp_err    <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            o_rule_wren <= 1'b0;
            o_rule_rden <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold_wr    <= head.wr;
                        hold_legal <= head_legal;
                        timer      <= '0;
                        state      <= ISSUE;
                        // Strobes are registered here so they are high for the whole ISSUE cycle.
                        if (head_legal) begin
                            o_rule_addr <= head.addr;
                            if (head.wr) begin
                                o_rule_wren  <= 1'b1;
                                o_rule_wdata <= head.wdata;
                            end else begin
                                o_rule_rden  <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    timer <= timer + 1'b1;
                    if (!hold_legal) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_rdata <= '0;
                        state       <= RSP;
                    end else if (hold_wr) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (i_rule_rdata_valid) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= i_rule_rdata;
                        state       <= RSP;
                    end else if (timer == TMR_LAST) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_rdata <= '0;
                        state       <= RSP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        if (o_rsp_err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parser_rule_cfg_master.sv
// Directed bench for the rule-bus master with a small Parser_Top read responder and bus/response logs.
module tb_parser_rule_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rule_wren;
    logic        rule_rden;
    logic [31:0] rule_addr;
    logic [31:0] rule_wdata;
    logic        rule_rdata_valid;
    logic [31:0] rule_rdata;
    logic        busy;
    logic [1:0]  err_cnt;

    logic        man_vld = 1'b0;
    logic [31:0] man_dat = '0;
    logic        auto_en = 1'b0;
    logic        auto_vld = 1'b0;
    logic [31:0] auto_dat = '0;
    logic        rden_d = 1'b0;
    logic [31:0] rd_addr_d = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit          ev_wr   [$];
    logic [31:0] ev_addr [$];
    logic [31:0] ev_dat  [$];
    int          ev_cyc  [$];
    logic [31:0] rs_dat  [$];
    logic        rs_err  [$];
    int          rs_cyc  [$];

    always #5 clk = ~clk;

    assign rule_rdata_valid = man_vld | auto_vld;
    assign rule_rdata       = auto_vld ? auto_dat : man_dat;

    parser_rule_cfg_master #(
        .CMD_DEPTH  (4),
        .RD_TIMEOUT (64),
        .ERR_CNT_W  (2)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_cmd_valid        (cmd_valid),
        .o_cmd_ready        (cmd_ready),
        .i_cmd_wr           (cmd_wr),
        .i_cmd_addr         (cmd_addr),
        .i_cmd_wdata        (cmd_wdata),
        .o_rsp_valid        (rsp_valid),
        .i_rsp_ready        (rsp_ready),
        .o_rsp_rdata        (rsp_rdata),
        .o_rsp_err          (rsp_err),
        .o_rule_wren        (rule_wren),
        .o_rule_rden        (rule_rden),
        .o_rule_addr        (rule_addr),
        .o_rule_wdata       (rule_wdata),
        .i_rule_rdata_valid (rule_rdata_valid),
        .i_rule_rdata       (rule_rdata),
        .o_busy             (busy),
        .o_err_cnt          (err_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Responder answers a read one cycle after the rden cycle, with data derived from the address.
    always @(negedge clk) begin
        auto_vld  = auto_en && rden_d;
        auto_dat  = 32'h5A5A_0000 ^ rd_addr_d;
        rden_d    = rule_rden;
        rd_addr_d = rule_addr;
    end

    always @(negedge clk) begin
        if (rule_wren || rule_rden) begin
            ev_wr.push_back(rule_wren);
            ev_addr.push_back(rule_addr);
            ev_dat.push_back(rule_wdata);
            ev_cyc.push_back(cyc);
        end
        if (rsp_valid) begin
            rs_dat.push_back(rsp_rdata);
            rs_err.push_back(rsp_err);
            rs_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    task automatic clear_logs();
        ev_wr.delete(); ev_addr.delete(); ev_dat.delete(); ev_cyc.delete();
        rs_dat.delete(); rs_err.delete(); rs_cyc.delete();
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        n_tests++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL push_ready addr=%h: ready=%b required 1 within 300 cycles", addr, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rden(output int c);
        int n = 0;
        while (!rule_rden && n < 50) begin @(negedge clk); n++; end
        c = cyc;
        n_tests++;
        if (!rule_rden) begin
            n_fail++;
            $display("FAIL wait_rden: rden=%b required 1 within 50 cycles", rule_rden);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        n_tests++;
        if (!rsp_valid) begin
            n_fail++;
            $display("FAIL wait_rsp: rsp_valid=%b required 1 within 200 cycles", rsp_valid);
        end
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b required 0 within 400 cycles", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if ({rule_wren, rule_rden, rsp_valid, rsp_err, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: wren,rden,rsp_vld,err,busy=%b required 00000",
                     {rule_wren, rule_rden, rsp_valid, rsp_err, busy});
        end
        n_tests++;
        if (rule_addr !== 32'h0 || rule_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", rule_addr, rule_wdata);
        end
        n_tests++;
        if (rsp_rdata !== 32'h0 || err_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: rdata=%h err_cnt=%0d required 0/0", rsp_rdata, err_cnt);
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid_read();
        int c;
        push_cmd(1'b0, 32'h0000_0100, 32'h0);
        push_cmd(1'b1, 32'h0000_0205, 32'h77);
        wait_rden(c);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rule_rden, rule_wren, rsp_valid, busy} !== 4'b0 || rule_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rden,wren,rsp_vld,busy=%b addr=%h required 0000/0",
                     {rule_rden, rule_wren, rsp_valid, busy}, rule_addr);
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: cmd_ready=%b required 1", cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || ev_wr.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_queue: busy=%b bus_events=%0d required 0/0", busy, ev_wr.size());
        end
    endtask

    task automatic test_write_pair();
        clear_logs();
        push_cmd(1'b1, 32'h0000_0200, 32'd12);
        push_cmd(1'b1, 32'h0000_0201, 32'd13);
        wait_idle();
        n_tests++;
        if (ev_wr.size() != 2) begin
            n_fail++;
            $display("FAIL wr_count: events=%0d required 2", ev_wr.size());
        end else begin
            n_tests++;
            if (!ev_wr[0] || ev_addr[0] !== 32'h200 || ev_dat[0] !== 32'd12) begin
                n_fail++;
                $display("FAIL wr_first: wr=%b addr=%h data=%h required 1/200/c", ev_wr[0], ev_addr[0], ev_dat[0]);
            end
            n_tests++;
            if (!ev_wr[1] || ev_addr[1] !== 32'h201 || ev_dat[1] !== 32'd13) begin
                n_fail++;
                $display("FAIL wr_second: wr=%b addr=%h data=%h required 1/201/d", ev_wr[1], ev_addr[1], ev_dat[1]);
            end
            n_tests++;
            if (ev_cyc[1] - ev_cyc[0] < 2) begin
                n_fail++;
                $display("FAIL wr_spacing: gap=%0d required >=2", ev_cyc[1] - ev_cyc[0]);
            end
        end
        n_tests++;
        if (rs_dat.size() != 0) begin
            n_fail++;
            $display("FAIL wr_no_rsp: rsp cycles=%0d required 0", rs_dat.size());
        end
        n_tests++;
        if (rule_addr !== 32'h201 || rule_wdata !== 32'd13) begin
            n_fail++;
            $display("FAIL wr_hold: addr=%h wdata=%h required 201/d", rule_addr, rule_wdata);
        end
    endtask

    task automatic test_read();
        int c;
        int bad = 0;
        clear_logs();
        push_cmd(1'b0, 32'h0000_0300, 32'h0);
        wait_rden(c);
        repeat (3) @(negedge clk);
        man_vld = 1'b1; man_dat = 32'h0001_0004;
        @(negedge clk);
        man_vld = 1'b0; man_dat = 32'h0;
        wait_rsp();
        n_tests++;
        if (rsp_rdata !== 32'h0001_0004 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data: rdata=%h err=%b required 00010004/0", rsp_rdata, rsp_err);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== 32'h0001_0004) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rd_hold: unstable cycles=%0d required 0", bad);
        end
        accept_rsp();
        n_tests++;
        if (rsp_valid !== 1'b0 || err_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL rd_done: rsp_valid=%b err_cnt=%0d required 0/0", rsp_valid, err_cnt);
        end
        wait_idle();
        n_tests++;
        if (ev_wr.size() != 1 || ev_wr[0] || ev_addr[0] !== 32'h300) begin
            n_fail++;
            $display("FAIL rd_bus: events=%0d required one read of 300", ev_wr.size());
        end
    endtask

    task automatic test_timeout();
        int c0;
        int c1;
        int n = 0;
        push_cmd(1'b0, 32'h0000_0400, 32'h0);
        wait_rden(c0);
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        c1 = cyc;
        n_tests++;
        if (!rsp_valid || (c1 - c0) != 64) begin
            n_fail++;
            $display("FAIL to_latency: rsp_valid=%b cycles=%0d required 1/64", rsp_valid, c1 - c0);
        end
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL to_rsp: err=%b rdata=%h required 1/0", rsp_err, rsp_rdata);
        end
        accept_rsp();
        n_tests++;
        if (err_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL to_errcnt: err_cnt=%0d required 1", err_cnt);
        end
        @(negedge clk);
        man_vld = 1'b1; man_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        man_vld = 1'b0; man_dat = 32'h0;
        clear_logs();
        repeat (4) @(negedge clk);
        n_tests++;
        if (rs_dat.size() != 0 || err_cnt !== 2'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_stray: rsp cycles=%0d err_cnt=%0d busy=%b required 0/1/0",
                     rs_dat.size(), err_cnt, busy);
        end
    endtask

    task automatic test_illegal_write();
        clear_logs();
        push_cmd(1'b1, 32'h0000_0600, 32'h55);
        wait_rsp();
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ill_rsp: err=%b rdata=%h required 1/0", rsp_err, rsp_rdata);
        end
        accept_rsp();
        n_tests++;
        if (err_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL ill_errcnt: err_cnt=%0d required 2", err_cnt);
        end
        wait_idle();
        n_tests++;
        if (ev_wr.size() != 0) begin
            n_fail++;
            $display("FAIL ill_bus: events=%0d required 0", ev_wr.size());
        end
    endtask

    task automatic test_back_to_back();
        bit          q_wr   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] q_addr [5] = '{32'h000, 32'h100, 32'h601, 32'h201, 32'h302};
        logic [31:0] q_dat  [5] = '{32'hA0, 32'h0, 32'h55, 32'hA3, 32'h0};
        bit          e_wr   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] e_addr [5] = '{32'h500, 32'h000, 32'h100, 32'h201, 32'h302};
        logic [31:0] e_dat  [5] = '{32'h0, 32'hA0, 32'h0, 32'hA3, 32'h0};
        logic [31:0] r_dat  [4] = '{32'hCAFE_0005, 32'h5A5A_0100, 32'h0, 32'h5A5A_0302};
        logic        r_err  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int c;
        int n = 0;
        clear_logs();
        push_cmd(1'b0, 32'h0000_0500, 32'h0);
        wait_rden(c);
        for (int k = 0; k < 4; k++) push_cmd(q_wr[k], q_addr[k], q_dat[k]);
        cmd_valid = 1'b1; cmd_wr = q_wr[4]; cmd_addr = q_addr[4]; cmd_wdata = q_dat[4];
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: cmd_ready=%b required 0 on 5th push", cmd_ready);
        end
        rs_dat.delete(); rs_err.delete(); rs_cyc.delete();
        auto_en = 1'b1; rsp_ready = 1'b1;
        man_vld = 1'b1; man_dat = 32'hCAFE_0005;
        @(negedge clk);
        man_vld = 1'b0; man_dat = 32'h0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        n_tests++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL b2b_5th_push: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        n_tests++;
        if (ev_wr.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_bus_count: events=%0d required 5", ev_wr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (ev_wr[i] != e_wr[i] || ev_addr[i] !== e_addr[i] || (e_wr[i] && ev_dat[i] !== e_dat[i])) begin
                    n_fail++;
                    $display("FAIL b2b_bus[%0d]: wr=%b addr=%h data=%h required %b/%h/%h",
                             i, ev_wr[i], ev_addr[i], ev_dat[i], e_wr[i], e_addr[i], e_dat[i]);
                end
            end
        end
        n_tests++;
        if (rs_dat.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_rsp_count: responses=%0d required 4", rs_dat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (rs_dat[i] !== r_dat[i] || rs_err[i] !== r_err[i]) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: rdata=%h err=%b required %h/%b",
                             i, rs_dat[i], rs_err[i], r_dat[i], r_err[i]);
                end
            end
            if (ev_cyc.size() > 1) begin
                n_tests++;
                if (ev_cyc[1] <= rs_cyc[0]) begin
                    n_fail++;
                    $display("FAIL b2b_order: write cycle=%0d read rsp cycle=%0d required write later",
                             ev_cyc[1], rs_cyc[0]);
                end
            end
        end
        n_tests++;
        if (err_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL b2b_errcnt: err_cnt=%0d required 3", err_cnt);
        end
        rsp_ready = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_err_saturate();
        push_cmd(1'b1, 32'h0000_0700, 32'h1);
        wait_rsp();
        n_tests++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_rsp: err=%b required 1", rsp_err);
        end
        accept_rsp();
        n_tests++;
        if (err_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_errcnt: err_cnt=%0d required 3 (saturated)", err_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset_mid_read();
        test_write_pair();
        test_read();
        test_timeout();
        test_illegal_write();
        test_back_to_back();
        test_err_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
